// File: rtl/fft_frame_scheduler_if.sv
// rtl/fft_frame_scheduler_if.sv - FIFO read port and FFT input stream bundle
// master = scheduler side (pops FIFO, drives stream); slave = FIFO/FFT side.
interface fft_frame_scheduler_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic [ADDR_WIDTH:0]   fifo_rd_level;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tready;
  logic                  m_tuser;
  logic                  m_tlast;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data, fifo_empty, fifo_rd_level,
    output m_tdata, m_tvalid, m_tuser, m_tlast,
    input  m_tready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data, fifo_empty, fifo_rd_level,
    input  m_tdata, m_tvalid, m_tuser, m_tlast,
    output m_tready
  );
endinterface

// File: rtl/fft_frame_scheduler.sv
// rtl/fft_frame_scheduler.sv - pops whole FFT frames from a FIFO onto a framed stream
// Waits for a full frame in the FIFO, streams it with SOF/EOF markers, optional inter-frame gap.
module fft_frame_scheduler #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 1024,
  parameter int GAP_CYCLES = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        flush,
  fft_frame_scheduler_if.master       bus,
  output logic                        busy,
  output logic                        frame_done,
  output logic [15:0]                 frame_cnt,
  output logic                        underrun
);
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    LAST_IDX  = CNT_W'(FRAME_LEN - 1);
  localparam logic [ADDR_WIDTH:0] FRAME_LVL = (ADDR_WIDTH + 1)'(FRAME_LEN);
  localparam logic [GAP_W-1:0]    GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN, ST_GAP} state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      pop_cnt_q;
  logic [GAP_W-1:0]      gap_cnt_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q;
  logic                  tuser_q;
  logic                  tlast_q;
  logic                  frame_done_q;
  logic [15:0]           frame_cnt_q;
  logic                  underrun_q;

  logic slot_free;
  logic pop;
  logic handshake;

  // The output register can take a new word when empty or being consumed this cycle.
  assign slot_free = !tvalid_q || bus.m_tready;
  assign pop       = (state_q == ST_STREAM) && !bus.fifo_empty && slot_free && !flush;
  assign handshake = tvalid_q && bus.m_tready;

  assign bus.fifo_rd_en = pop;
  assign bus.m_tdata    = tdata_q;
  assign bus.m_tvalid   = tvalid_q;
  assign bus.m_tuser    = tuser_q;
  assign bus.m_tlast    = tlast_q;
  assign busy           = (state_q != ST_IDLE);
  assign frame_done     = frame_done_q;
  assign frame_cnt      = frame_cnt_q;
  assign underrun       = underrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pop_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tuser_q      <= 1'b0;
      tlast_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      underrun_q   <= 1'b0;
    end else if (flush) begin
      state_q      <= ST_IDLE;
      pop_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      tvalid_q     <= 1'b0;
      tuser_q      <= 1'b0;
      tlast_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      underrun_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      if (pop) begin
        tdata_q  <= bus.fifo_rd_data;
        tvalid_q <= 1'b1;
        tuser_q  <= (pop_cnt_q == '0);
        tlast_q  <= (pop_cnt_q == LAST_IDX);
      end else if (handshake) begin
        tvalid_q <= 1'b0;
        tuser_q  <= 1'b0;
        tlast_q  <= 1'b0;
      end

      // Stalled on an empty FIFO mid-frame: flag it and simply wait for data.
      if (state_q == ST_STREAM && bus.fifo_empty && slot_free) begin
        underrun_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (enable && bus.fifo_rd_level >= FRAME_LVL) begin
            state_q   <= ST_STREAM;
            pop_cnt_q <= '0;
          end
        end
        ST_STREAM: begin
          if (pop) begin
            if (pop_cnt_q == LAST_IDX) begin
              pop_cnt_q <= '0;
              state_q   <= ST_DRAIN;
            end else begin
              pop_cnt_q <= pop_cnt_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (handshake && tlast_q) begin
            frame_done_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_q + 16'd1;
            gap_cnt_q    <= '0;
            state_q      <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb/tb_fft_frame_scheduler.sv - directed bench for fft_frame_scheduler
// Lane 0 has no inter-frame gap, lane 1 uses GAP_CYCLES=3; each lane owns a FIFO model and stream monitor.
module tb_fft_frame_scheduler;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int FL = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic enable;
  logic flush;
  logic tready;
  int   cyc;
  int   total;
  int   bad;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : lane
    fft_frame_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    logic        busy;
    logic        done;
    logic        und;
    logic [15:0] fcnt;
    logic [31:0] mem [32];
    int          wp;
    int          rp;
    logic        force_empty;
    logic        clr;
    int          n_pop;
    int          n_hs;
    int          n_done;
    int          viol;
    int          done_cyc;
    int          pop_cyc [32];
    int          hs_cyc  [32];
    logic [31:0] hs_data [32];
    logic        hs_user [32];
    logic        hs_last [32];
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_user;
    logic        prev_last;
    logic        hold_bad;

    always_comb begin
      bus.fifo_rd_data  = mem[rp % 32];
      bus.fifo_empty    = (wp == rp) || force_empty;
      bus.fifo_rd_level = 5'(wp - rp);
      bus.m_tready      = tready;
    end

    fft_frame_scheduler #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_LEN(FL), .GAP_CYCLES(3 * g)
    ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush), .bus(bus.master),
      .busy(busy), .frame_done(done), .frame_cnt(fcnt), .underrun(und)
    );

    assign hold_bad = prev_stall && (!bus.m_tvalid || bus.m_tdata !== prev_data ||
                      bus.m_tuser !== prev_user || bus.m_tlast !== prev_last);

    always @(posedge clk) begin
      if (bus.fifo_rd_en) rp <= rp + 1;
      if (clr) begin
        n_pop <= 0; n_hs <= 0; n_done <= 0; viol <= 0; prev_stall <= 1'b0;
      end else begin
        if (bus.fifo_rd_en) begin
          pop_cyc[n_pop % 32] <= cyc;
          n_pop <= n_pop + 1;
        end
        if (bus.m_tvalid && bus.m_tready) begin
          hs_cyc[n_hs % 32]  <= cyc;
          hs_data[n_hs % 32] <= bus.m_tdata;
          hs_user[n_hs % 32] <= bus.m_tuser;
          hs_last[n_hs % 32] <= bus.m_tlast;
          n_hs <= n_hs + 1;
        end
        if (done) begin
          n_done   <= n_done + 1;
          done_cyc <= cyc;
        end
        viol <= viol + int'(hold_bad) + int'(bus.fifo_rd_en && bus.m_tvalid && !bus.m_tready);
        prev_stall <= bus.m_tvalid && !bus.m_tready;
        prev_data  <= bus.m_tdata;
        prev_user  <= bus.m_tuser;
        prev_last  <= bus.m_tlast;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push0(input int v);
    lane[0].mem[lane[0].wp % 32] = 32'(v);
    lane[0].wp = lane[0].wp + 1;
  endtask

  task automatic push1(input int v);
    lane[1].mem[lane[1].wp % 32] = 32'(v);
    lane[1].wp = lane[1].wp + 1;
  endtask

  task automatic clr_mon();
    lane[0].clr = 1'b1;
    lane[1].clr = 1'b1;
    tick(1);
    lane[0].clr = 1'b0;
    lane[1].clr = 1'b0;
  endtask

  task automatic wait_done0(input int need, input string tag);
    for (int i = 0; i < 300 && lane[0].n_done < need; i++) tick(1);
    chk(tag, 32'(lane[0].n_done >= need), 32'd1);
  endtask

  task automatic chk_frame0(input string tag, input int base, input int first);
    for (int i = 0; i < FL; i++) begin
      chk({tag, "_data"}, lane[0].hs_data[first + i], 32'(base + i));
    end
    chk({tag, "_user"}, {30'd0, lane[0].hs_user[first + 1], lane[0].hs_user[first]}, 32'd1);
    chk({tag, "_last"}, {30'd0, lane[0].hs_last[first + FL - 1], lane[0].hs_last[first + FL - 2]}, 32'd2);
  endtask

  int t0;

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; tready = 1'b0;
    lane[0].clr = 1'b0; lane[1].clr = 1'b0;
    lane[0].force_empty = 1'b0; lane[1].force_empty = 1'b0;
    tick(3);
    chk("rst_tvalid", 32'(lane[0].bus.m_tvalid), 32'd0);
    chk("rst_flags", {27'd0, lane[0].bus.m_tuser, lane[0].bus.m_tlast, lane[0].busy,
                      lane[0].done, lane[0].und}, 32'd0);
    chk("rst_fcnt", 32'(lane[0].fcnt), 32'd0);
    chk("rst_rden", 32'(lane[0].bus.fifo_rd_en), 32'd0);
    rst_n = 1'b1;
    tick(1);
    clr_mon();

    // 1: full frame, continuous ready
    enable = 1'b1; tready = 1'b1;
    for (int i = 0; i < FL; i++) push0(i);
    t0 = cyc;
    wait_done0(1, "t1_timeout");
    tick(2);
    chk_frame0("t1", 0, 0);
    chk("t1_npop", 32'(lane[0].n_pop), 32'd8);
    chk("t1_pop_span", 32'(lane[0].pop_cyc[7] - lane[0].pop_cyc[0]), 32'd7);
    chk("t1_first_pop", 32'(lane[0].pop_cyc[0] - t0), 32'd1);
    chk("t1_first_valid", 32'(lane[0].hs_cyc[0] - t0), 32'd2);
    chk("t1_done_cnt", 32'(lane[0].n_done), 32'd1);
    chk("t1_done_cyc", 32'(lane[0].done_cyc - lane[0].hs_cyc[7]), 32'd1);
    chk("t1_fcnt", 32'(lane[0].fcnt), 32'd1);
    chk("t1_underrun", 32'(lane[0].und), 32'd0);
    chk("t1_idle", 32'(lane[0].busy), 32'd0);

    // 2: level 7 holds off, 8th word starts the frame
    clr_mon();
    for (int i = 0; i < FL - 1; i++) push0(8 + i);
    tick(6);
    chk("t2_no_pop", 32'(lane[0].n_pop), 32'd0);
    chk("t2_no_busy", 32'(lane[0].busy), 32'd0);
    push0(15);
    t0 = cyc;
    wait_done0(1, "t2_timeout");
    chk("t2_first_pop", 32'(lane[0].pop_cyc[0] - t0), 32'd1);
    chk("t2_first_valid", 32'(lane[0].hs_cyc[0] - t0), 32'd2);
    chk("t2_fcnt", 32'(lane[0].fcnt), 32'd2);

    // 3: ready toggling every cycle
    clr_mon();
    for (int i = 0; i < FL; i++) push0(16 + i);
    for (int i = 0; i < 300 && lane[0].n_done < 1; i++) begin
      tready = ~tready;
      tick(1);
    end
    tready = 1'b1;
    chk("t3_timeout", 32'(lane[0].n_done), 32'd1);
    chk_frame0("t3", 16, 0);
    chk("t3_hold_viol", 32'(lane[0].viol), 32'd0);
    chk("t3_nhs", 32'(lane[0].n_hs), 32'd8);
    chk("t3_fcnt", 32'(lane[0].fcnt), 32'd3);

    // 4: FIFO runs dry after 4 pops, then refills
    clr_mon();
    for (int i = 0; i < FL; i++) push0(32 + i);
    for (int i = 0; i < 100 && lane[0].n_pop < 4; i++) tick(1);
    lane[0].force_empty = 1'b1;
    tick(5);
    chk("t4_underrun", 32'(lane[0].und), 32'd1);
    chk("t4_stall_pops", 32'(lane[0].n_pop), 32'd4);
    chk("t4_stall_valid", 32'(lane[0].bus.m_tvalid), 32'd0);
    chk("t4_stall_busy", 32'(lane[0].busy), 32'd1);
    lane[0].force_empty = 1'b0;
    wait_done0(1, "t4_timeout");
    chk_frame0("t4", 32, 0);
    chk("t4_nhs", 32'(lane[0].n_hs), 32'd8);
    chk("t4_hold_viol", 32'(lane[0].viol), 32'd0);
    chk("t4_sticky", 32'(lane[0].und), 32'd1);
    chk("t4_fcnt", 32'(lane[0].fcnt), 32'd4);

    // 5: flush when sample 3 is due
    clr_mon();
    for (int i = 0; i < FL; i++) push0(40 + i);
    for (int i = 0; i < 100 && lane[0].n_pop < 3; i++) tick(1);
    flush = 1'b1;
    #1;
    chk("t5_flush_rden", 32'(lane[0].bus.fifo_rd_en), 32'd0);
    tick(1);
    flush = 1'b0;
    chk("t5_busy", 32'(lane[0].busy), 32'd0);
    chk("t5_tvalid", 32'(lane[0].bus.m_tvalid), 32'd0);
    chk("t5_underrun", 32'(lane[0].und), 32'd0);
    chk("t5_fcnt", 32'(lane[0].fcnt), 32'd0);
    clr_mon();
    for (int i = 0; i < 3; i++) push0(48 + i);
    wait_done0(1, "t5_timeout");
    chk_frame0("t5", 43, 0);
    chk("t5_fcnt_after", 32'(lane[0].fcnt), 32'd1);

    // 6a: two queued frames with no gap
    clr_mon();
    for (int i = 0; i < 2 * FL; i++) push0(60 + i);
    wait_done0(2, "t6a_timeout");
    chk_frame0("t6a", 68, 8);
    chk("t6a_gap", 32'(lane[0].pop_cyc[8] - lane[0].hs_cyc[7]), 32'd2);
    chk("t6a_fcnt", 32'(lane[0].fcnt), 32'd3);

    // 6b: GAP_CYCLES=3 adds exactly three cycles to the frame-to-frame spacing
    clr_mon();
    for (int i = 0; i < 2 * FL; i++) push1(256 + i);
    for (int i = 0; i < 300 && lane[1].n_done < 2; i++) tick(1);
    chk("t6b_timeout", 32'(lane[1].n_done), 32'd2);
    chk("t6b_gap", 32'(lane[1].pop_cyc[8] - lane[1].hs_cyc[7]), 32'd5);
    chk("t6b_first2", lane[1].hs_data[8], 32'd264);
    chk("t6b_user2", 32'(lane[1].hs_user[8]), 32'd1);
    chk("t6b_last1", 32'(lane[1].hs_last[7]), 32'd1);
    chk("t6b_fcnt", 32'(lane[1].fcnt), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
